// File: rtl/bin2bcd_conv.sv
// Sequential shift-add-3 binary-to-BCD converter for the 4-digit display.
// Define BIN2BCD_SAT_EN to clamp overflowing results to 9999.
module bin2bcd_conv #(
  parameter int W_BIN = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_BIN-1:0] i_bin,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [15:0]      o_bcd,
  output logic             o_valid,
  output logic             o_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic OVF_ABLE = (W_BIN >= 14);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W_BIN-1:0] r_shift;
  logic [19:0]      r_dig;
  logic [4:0]       r_cnt;
  logic             r_ovf_q;
  logic [15:0]      r_bcd;
  logic             r_valid;
  logic             r_ovf;

  logic [19:0]      w_adj;
  logic [19:0]      w_dig_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_ovf_in;
  logic             w_ovf_fin;
  logic [15:0]      w_bcd_fin;

  always_comb begin
    w_adj = r_dig;
    for (int d = 0; d < 5; d++) begin
      if (r_dig[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_dig[4*d +: 4] + 4'd3;
    end
  end

  assign w_dig_nxt = {w_adj[18:0], r_shift[W_BIN-1]};
  assign w_accept  = (r_state == S_IDLE) && i_valid;
  assign w_last    = (r_state == S_SHIFT) && (r_cnt == 5'd1);
  assign w_ovf_in  = OVF_ABLE &&
    ({{(32-W_BIN){1'b0}}, i_bin} >= 32'd10000);

  // Any ten-thousands content also means the value left the 4-digit range.
  assign w_ovf_fin = r_ovf_q | w_adj[19] | (|w_dig_nxt[19:16]);

`ifdef BIN2BCD_SAT_EN
  assign w_bcd_fin = w_ovf_fin ? 16'h9999 : w_dig_nxt[15:0];
`else
  assign w_bcd_fin = w_dig_nxt[15:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_dig   <= '0;
      r_cnt   <= '0;
      r_ovf_q <= 1'b0;
    end else if (w_accept) begin
      r_shift <= i_bin;
      r_dig   <= '0;
      r_cnt   <= 5'(W_BIN);
      r_ovf_q <= w_ovf_in;
    end else if (r_state == S_SHIFT) begin
      r_shift <= r_shift << 1;
      r_dig   <= w_dig_nxt;
      r_cnt   <= r_cnt - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd   <= 16'h0000;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_bcd <= w_bcd_fin;
        r_ovf <= w_ovf_fin;
      end
    end
  end

  assign o_bcd   = r_bcd;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed bench for bin2bcd_conv: 14-bit instance plus an 8-bit
// instance swept over its whole input range.
module tb_bin2bcd_conv;

`ifdef BIN2BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] i_bin;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_bcd;
  logic        o_valid;
  logic        o_ovf;

  logic [7:0]  b8_bin;
  logic        b8_valid;
  logic        b8_ready;
  logic [15:0] b8_bcd;
  logic        b8_ovalid;
  logic        b8_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin2bcd_conv #(.W_BIN(14)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_bin  (i_bin),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_bcd  (o_bcd),
    .o_valid(o_valid),
    .o_ovf  (o_ovf)
  );

  bin2bcd_conv #(.W_BIN(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_bin  (b8_bin),
    .i_valid(b8_valid),
    .o_ready(b8_ready),
    .o_bcd  (b8_bcd),
    .o_valid(b8_ovalid),
    .o_ovf  (b8_ovf)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd_ref(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic run14(input string tag,
                       input logic [13:0] v,
                       input logic [15:0] e_bcd,
                       input logic e_ovf);
    int cyc, lat, busy;
    logic [15:0] got;
    logic gov;
    got = 'x;
    gov = 1'bx;
    @(negedge clk);
    i_bin   = v;
    i_valid = 1'b1;
    check({tag, "_rdy"}, 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    cyc = 0; lat = -1; busy = 0;
    while (!o_ready && cyc < 40) begin
      busy++;
      if (o_valid) begin
        lat = cyc;
        got = o_bcd;
        gov = o_ovf;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"},  32'(lat),  32'd14);
    check({tag, "_busy"}, 32'(busy), 32'd15);
    check({tag, "_bcd"},  32'(got),  32'(e_bcd));
    check({tag, "_ovf"},  32'(gov),  32'(e_ovf));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, 32'(o_bcd), 32'(e_bcd));
  endtask

  task automatic run8(input int v);
    int cyc, lat;
    logic [15:0] got;
    logic gov;
    got = 'x;
    gov = 1'bx;
    @(negedge clk);
    b8_bin   = 8'(v);
    b8_valid = 1'b1;
    @(posedge clk);
    #1;
    b8_valid = 1'b0;
    cyc = 0; lat = -1;
    while (!b8_ready && cyc < 30) begin
      if (b8_ovalid) begin
        lat = cyc;
        got = b8_bcd;
        gov = b8_ovf;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check($sformatf("w8_lat_%0d", v), 32'(lat), 32'd8);
    check($sformatf("w8_bcd_%0d", v), 32'(got),
          32'(bcd_ref(v)));
    check($sformatf("w8_ovf_%0d", v), 32'(gov), 32'd0);
  endtask

  initial begin
    int t1, t2, np, nv;
    logic [15:0] b1, b2;

    rst_n    = 1'b0;
    i_bin    = '0;
    i_valid  = 1'b0;
    b8_bin   = '0;
    b8_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_bcd",   32'(o_bcd),   32'h0);
    check("rst_ovf",   32'(o_ovf),   32'd0);
    rst_n = 1'b1;

    run14("t1_zero", 14'd0,    16'h0000, 1'b0);
    run14("t2_1234", 14'd1234, 16'h1234, 1'b0);
    run14("t2_9999", 14'd9999, 16'h9999, 1'b0);

    // Back-to-back with i_valid held; i_bin changes mid-conversion.
    @(negedge clk);
    i_bin   = 14'd7;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    t1 = -1; t2 = -1; np = 0; b1 = 'x; b2 = 'x;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) i_bin = 14'd42;
      if (c == 16) begin
        i_valid = 1'b0;
        i_bin   = 14'd99;
      end
      if (o_valid) begin
        np++;
        if (t1 < 0) begin
          t1 = c;
          b1 = o_bcd;
        end else begin
          t2 = c;
          b2 = o_bcd;
        end
      end
      @(posedge clk);
      #1;
    end
    check("t4_first_bcd",  32'(b1), 32'h0007);
    check("t4_second_bcd", 32'(b2), 32'h0042);
    check("t4_first_t",    32'(t1), 32'd14);
    check("t4_gap",        32'(t2 - t1), 32'd16);
    check("t4_pulses",     32'(np), 32'd2);

    run14("t3_12345", 14'd12345,
          SAT ? 16'h9999 : 16'h2345, 1'b1);
    run14("t3_16383", 14'd16383,
          SAT ? 16'h9999 : 16'h6383, 1'b1);
    run14("t3_10000", 14'd10000,
          SAT ? 16'h9999 : 16'h0000, 1'b1);
    run14("t3_9999b", 14'd9999, 16'h9999, 1'b0);
    run14("t3_12345b", 14'd12345,
          SAT ? 16'h9999 : 16'h2345, 1'b1);

    // Abort a conversion with reset part-way through SHIFT.
    @(negedge clk);
    i_bin   = 14'd5555;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_bcd",   32'(o_bcd),   32'h0);
    check("t5_rst_ovf",   32'(o_ovf),   32'd0);
    check("t5_rst_valid", 32'(o_valid), 32'd0);
    check("t5_rst_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) nv++;
    end
    check("t5_no_valid", 32'(nv), 32'd0);
    check("t5_ready",    32'(o_ready), 32'd1);
    check("t5_bcd_idle", 32'(o_bcd), 32'h0);
    run14("t5_4000", 14'h0FA0, 16'h4000, 1'b0);

    for (int v = 0; v < 256; v++) run8(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
